// File: rtl/ehl_ddr_wrlvl_ctrl.sv
// ehl_ddr_wrlvl_ctrl
// DDR3 write-leveling sequencer. Walks the enabled ranks in ascending order,
// switches each into write-leveling mode via MR1, runs every byte-lane
// training engine in parallel, stores the coefficients for the rank and
// switches the rank back out of write-leveling mode.
module ehl_ddr_wrlvl_ctrl #(
    parameter int LANES = 2,
    parameter int TMO   = 1023
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [3:0]           rank_en,
    input  logic [15:0]          mr1_val,
    input  logic [5:0]           twlmrd,
    output logic                 mrs_req,
    output logic [1:0]           mrs_rank,
    output logic [15:0]          mrs_data,
    input  logic                 mrs_ack,
    output logic [3:0]           rank_sel,
    output logic [LANES-1:0]     trng_init,
    input  logic [LANES-1:0]     trng_done,
    input  logic [LANES-1:0]     trng_status,
    input  logic [4*LANES-1:0]   trng_result,
    output logic                 res_we,
    output logic [1:0]           res_rank,
    output logic [4*LANES-1:0]   res_data,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           fail_mask
);

    localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TMO);

    typedef enum logic [3:0] {
        IDLE,
        SEL,
        MRS_ON,
        WAIT_ON,
        TRN_START,
        TRN_WAIT,
        STORE,
        MRS_OFF,
        WAIT_OFF,
        FIN
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           rank_en_q, rank_en_d;
    logic [3:0]           trained_q, trained_d;
    logic [1:0]           rank_q, rank_d;
    logic [3:0]           rank_sel_q, rank_sel_d;
    logic                 mrs_req_q, mrs_req_d;
    logic [1:0]           mrs_rank_q, mrs_rank_d;
    logic [15:0]          mrs_data_q, mrs_data_d;
    logic [LANES-1:0]     trng_init_q, trng_init_d;
    logic                 res_we_q, res_we_d;
    logic [1:0]           res_rank_q, res_rank_d;
    logic [4*LANES-1:0]   res_data_q, res_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [3:0]           fail_mask_q, fail_mask_d;
    logic [5:0]           wait_cnt_q, wait_cnt_d;
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;

    logic [3:0]           pending;
    logic                 sel_found;
    logic [1:0]           sel_idx;
    logic [5:0]           wait_load;
    logic [15:0]          mr1_wl_on;
    logic [15:0]          mr1_wl_off;

    assign pending    = rank_en_q & ~trained_q;
    // A zero tWLMRD setting still waits one cycle.
    assign wait_load  = (twlmrd == 6'd0) ? 6'd1 : twlmrd;
    // MR1 bit 7 is the write-leveling enable.
    assign mr1_wl_on  = {mr1_val[15:8], 1'b1, mr1_val[6:0]};
    assign mr1_wl_off = {mr1_val[15:8], 1'b0, mr1_val[6:0]};

    // Lowest-index enabled rank that has not been trained yet.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (pending[r]) begin
                sel_found = 1'b1;
                sel_idx   = 2'(r);
            end
        end
    end

    // Next-state logic; every output register is computed from the state being entered.
    always_comb begin
        state_d     = state_q;
        rank_en_d   = rank_en_q;
        trained_d   = trained_q;
        rank_d      = rank_q;
        rank_sel_d  = rank_sel_q;
        mrs_req_d   = mrs_req_q;
        mrs_rank_d  = mrs_rank_q;
        mrs_data_d  = mrs_data_q;
        trng_init_d = '0;
        res_we_d    = 1'b0;
        res_rank_d  = res_rank_q;
        res_data_d  = res_data_q;
        done_d      = 1'b0;
        fail_mask_d = fail_mask_q;
        wait_cnt_d  = wait_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    fail_mask_d = 4'd0;
                    rank_en_d   = rank_en;
                    trained_d   = 4'd0;
                    state_d     = SEL;
                end
            end
            SEL: begin
                if (sel_found) begin
                    rank_d     = sel_idx;
                    rank_sel_d = 4'b0001 << sel_idx;
                    mrs_req_d  = 1'b1;
                    mrs_rank_d = sel_idx;
                    mrs_data_d = mr1_wl_on;
                    state_d    = MRS_ON;
                end else begin
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            MRS_ON: begin
                if (mrs_ack) begin
                    mrs_req_d  = 1'b0;
                    wait_cnt_d = wait_load;
                    state_d    = WAIT_ON;
                end
            end
            WAIT_ON: begin
                wait_cnt_d = wait_cnt_q - 6'd1;
                if (wait_cnt_q <= 6'd1) begin
                    trng_init_d = '1;
                    tmo_cnt_d   = TMO_LOAD;
                    state_d     = TRN_START;
                end
            end
            TRN_START: begin
                tmo_cnt_d = tmo_cnt_q - TW'(1);
                state_d   = TRN_WAIT;
            end
            TRN_WAIT: begin
                tmo_cnt_d = tmo_cnt_q - TW'(1);
                if (&trng_done) begin
                    res_we_d   = 1'b1;
                    res_rank_d = rank_q;
                    res_data_d = trng_result;
                    if (!(&trng_status)) begin
                        fail_mask_d[rank_q] = 1'b1;
                    end
                    state_d = STORE;
                end else if (tmo_cnt_q <= TW'(1)) begin
                    // Timed out: skip the result write but still leave leveling mode.
                    fail_mask_d[rank_q] = 1'b1;
                    mrs_req_d  = 1'b1;
                    mrs_rank_d = rank_q;
                    mrs_data_d = mr1_wl_off;
                    state_d    = MRS_OFF;
                end
            end
            STORE: begin
                mrs_req_d  = 1'b1;
                mrs_rank_d = rank_q;
                mrs_data_d = mr1_wl_off;
                state_d    = MRS_OFF;
            end
            MRS_OFF: begin
                if (mrs_ack) begin
                    mrs_req_d  = 1'b0;
                    wait_cnt_d = wait_load;
                    state_d    = WAIT_OFF;
                end
            end
            WAIT_OFF: begin
                wait_cnt_d = wait_cnt_q - 6'd1;
                if (wait_cnt_q <= 6'd1) begin
                    trained_d[rank_q] = 1'b1;
                    rank_sel_d        = 4'd0;
                    state_d           = SEL;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset returns everything to idle and zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rank_en_q   <= 4'd0;
            trained_q   <= 4'd0;
            rank_q      <= 2'd0;
            rank_sel_q  <= 4'd0;
            mrs_req_q   <= 1'b0;
            mrs_rank_q  <= 2'd0;
            mrs_data_q  <= 16'd0;
            trng_init_q <= '0;
            res_we_q    <= 1'b0;
            res_rank_q  <= 2'd0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_mask_q <= 4'd0;
            wait_cnt_q  <= 6'd0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rank_en_q   <= rank_en_d;
            trained_q   <= trained_d;
            rank_q      <= rank_d;
            rank_sel_q  <= rank_sel_d;
            mrs_req_q   <= mrs_req_d;
            mrs_rank_q  <= mrs_rank_d;
            mrs_data_q  <= mrs_data_d;
            trng_init_q <= trng_init_d;
            res_we_q    <= res_we_d;
            res_rank_q  <= res_rank_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_mask_q <= fail_mask_d;
            wait_cnt_q  <= wait_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign mrs_req   = mrs_req_q;
    assign mrs_rank  = mrs_rank_q;
    assign mrs_data  = mrs_data_q;
    assign rank_sel  = rank_sel_q;
    assign trng_init = trng_init_q;
    assign res_we    = res_we_q;
    assign res_rank  = res_rank_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_ehl_ddr_wrlvl_ctrl.sv
// Directed testbench for ehl_ddr_wrlvl_ctrl with a command-path responder,
// a per-rank training engine model and result / MRS logging.
`timescale 1ns/1ps
module tb_ehl_ddr_wrlvl_ctrl;

    localparam int LANES = 2;
    localparam int TMO   = 1023;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic [3:0]           rank_en;
    logic [15:0]          mr1_val;
    logic [5:0]           twlmrd;
    logic                 mrs_req;
    logic [1:0]           mrs_rank;
    logic [15:0]          mrs_data;
    logic                 mrs_ack;
    logic [3:0]           rank_sel;
    logic [LANES-1:0]     trng_init;
    logic [LANES-1:0]     trng_done;
    logic [LANES-1:0]     trng_status;
    logic [4*LANES-1:0]   trng_result;
    logic                 res_we;
    logic [1:0]           res_rank;
    logic [4*LANES-1:0]   res_data;
    logic                 busy;
    logic                 done;
    logic [3:0]           fail_mask;

    int n_cmp = 0;
    int n_bad = 0;

    // command path responder state and log of accepted MRS requests
    int          ack_delay = 0;
    int          req_age   = 0;
    int          mrs_cnt   = 0;
    logic [1:0]  mrs_rank_log [0:7];
    logic [15:0] mrs_data_log [0:7];
    logic [3:0]  mrs_sel_log  [0:7];

    // result write log
    int          res_cnt = 0;
    logic [1:0]  res_rank_log [0:7];
    logic [7:0]  res_data_log [0:7];

    // training engine model
    int          eng_delay = 520;
    bit          eng_never = 1'b0;
    int          eng_cnt   = 0;
    int          eng_r;
    logic [7:0]  eng_result [0:3];
    logic [1:0]  eng_status [0:3];

    ehl_ddr_wrlvl_ctrl #(.LANES(LANES), .TMO(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .rank_en     (rank_en),
        .mr1_val     (mr1_val),
        .twlmrd      (twlmrd),
        .mrs_req     (mrs_req),
        .mrs_rank    (mrs_rank),
        .mrs_data    (mrs_data),
        .mrs_ack     (mrs_ack),
        .rank_sel    (rank_sel),
        .trng_init   (trng_init),
        .trng_done   (trng_done),
        .trng_status (trng_status),
        .trng_result (trng_result),
        .res_we      (res_we),
        .res_rank    (res_rank),
        .res_data    (res_data),
        .busy        (busy),
        .done        (done),
        .fail_mask   (fail_mask)
    );

    always #5 clk = ~clk;

    function automatic int sel_to_idx(input logic [3:0] s);
        case (s)
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    // Command path: acknowledge a request after ack_delay cycles of it being visible.
    initial begin
        mrs_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mrs_req) begin
                if (req_age == ack_delay) begin
                    mrs_ack = 1'b1;
                    if (mrs_cnt < 8) begin
                        mrs_rank_log[mrs_cnt] = mrs_rank;
                        mrs_data_log[mrs_cnt] = mrs_data;
                        mrs_sel_log[mrs_cnt]  = rank_sel;
                    end
                    mrs_cnt++;
                end
                req_age++;
            end else begin
                mrs_ack = 1'b0;
                req_age = 0;
            end
        end
    end

    // Result-write monitor.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (res_we) begin
                if (res_cnt < 8) begin
                    res_rank_log[res_cnt] = res_rank;
                    res_data_log[res_cnt] = res_data;
                end
                res_cnt++;
            end
        end
    end

    // Engine model: restart on init, raise done eng_delay cycles later.
    initial begin
        trng_done   = '0;
        trng_status = '0;
        trng_result = '0;
        forever begin
            @(posedge clk); #1;
            if (trng_init == '1) begin
                trng_done = '0;
                eng_cnt   = eng_delay;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0 && !eng_never) begin
                    eng_r       = sel_to_idx(rank_sel);
                    trng_status = eng_status[eng_r];
                    trng_result = eng_result[eng_r];
                    trng_done   = '1;
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        mrs_cnt = 0;
        res_cnt = 0;
    endtask

    task automatic pulse_start(input logic [3:0] en);
        rank_en = en;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({mrs_req, mrs_rank, mrs_data} !== 19'd0) begin
            n_bad++; $display("FAIL reset_mrs: got %0h want 0", {mrs_req, mrs_rank, mrs_data});
        end
        n_cmp++;
        if ({rank_sel, trng_init, res_we, res_rank, res_data} !== 17'd0) begin
            n_bad++; $display("FAIL reset_trn: got %0h want 0", {rank_sel, trng_init, res_we, res_rank, res_data});
        end
        n_cmp++;
        if ({busy, done, fail_mask} !== 6'd0) begin
            n_bad++; $display("FAIL reset_status: got %0h want 0", {busy, done, fail_mask});
        end
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle_busy: got %0b want 0", busy);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_single_rank();
        bit ok; int cyc;
        clear_logs();
        mr1_val = 16'h0044; twlmrd = 6'd4; ack_delay = 0; eng_never = 1'b0;
        eng_result[0] = 8'h95; eng_status[0] = 2'b11;
        pulse_start(4'b0001);
        wait_done(5000, ok, cyc);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_done: got timeout want done"); end
        n_cmp++;
        if (cyc !== 534) begin n_bad++; $display("FAIL single_latency: got %0d want 534", cyc); end
        n_cmp++;
        if (mrs_cnt !== 2) begin n_bad++; $display("FAIL single_mrs_cnt: got %0d want 2", mrs_cnt); end
        n_cmp++;
        if (mrs_data_log[0] !== 16'h00C4 || mrs_rank_log[0] !== 2'd0) begin
            n_bad++; $display("FAIL single_mrs_on: got %h/%0d want 00c4/0", mrs_data_log[0], mrs_rank_log[0]);
        end
        n_cmp++;
        if (mrs_data_log[1] !== 16'h0044) begin
            n_bad++; $display("FAIL single_mrs_off: got %h want 0044", mrs_data_log[1]);
        end
        n_cmp++;
        if (res_cnt !== 1 || res_rank_log[0] !== 2'd0 || res_data_log[0] !== 8'h95) begin
            n_bad++; $display("FAIL single_res: got cnt=%0d rank=%0d data=%h want 1/0/95", res_cnt, res_rank_log[0], res_data_log[0]);
        end
        n_cmp++;
        if (fail_mask !== 4'b0000) begin n_bad++; $display("FAIL single_fail_mask: got %b want 0000", fail_mask); end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL single_done_pulse: got done,busy=%b want 00", {done, busy}); end
        $display("single_rank: cycles=%0d mrs=%0d res=%0d fail=%b", cyc, mrs_cnt, res_cnt, fail_mask);
    endtask

    task automatic test_two_ranks();
        bit ok; int cyc;
        clear_logs();
        eng_result[1] = 8'h37; eng_status[1] = 2'b11;
        eng_result[3] = 8'hA1; eng_status[3] = 2'b11;
        pulse_start(4'b1010);
        rank_en = 4'b1111;   // must not affect the run in progress
        wait_done(5000, ok, cyc);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL two_done: got timeout want done"); end
        n_cmp++;
        if (cyc !== 1067) begin n_bad++; $display("FAIL two_latency: got %0d want 1067", cyc); end
        n_cmp++;
        if (mrs_cnt !== 4) begin n_bad++; $display("FAIL two_mrs_cnt: got %0d want 4", mrs_cnt); end
        n_cmp++;
        if ({mrs_rank_log[0], mrs_rank_log[1], mrs_rank_log[2], mrs_rank_log[3]} !== 8'b01_01_11_11) begin
            n_bad++; $display("FAIL two_mrs_ranks: got %0d %0d %0d %0d want 1 1 3 3",
                              mrs_rank_log[0], mrs_rank_log[1], mrs_rank_log[2], mrs_rank_log[3]);
        end
        n_cmp++;
        if (mrs_sel_log[0] !== 4'b0010 || mrs_sel_log[2] !== 4'b1000) begin
            n_bad++; $display("FAIL two_rank_sel: got %b,%b want 0010,1000", mrs_sel_log[0], mrs_sel_log[2]);
        end
        n_cmp++;
        if (mrs_data_log[2] !== 16'h00C4 || mrs_data_log[3] !== 16'h0044) begin
            n_bad++; $display("FAIL two_mrs_data: got %h,%h want 00c4,0044", mrs_data_log[2], mrs_data_log[3]);
        end
        n_cmp++;
        if (res_cnt !== 2 || res_rank_log[0] !== 2'd1 || res_rank_log[1] !== 2'd3) begin
            n_bad++; $display("FAIL two_res_rank: got cnt=%0d ranks=%0d,%0d want 2/1,3", res_cnt, res_rank_log[0], res_rank_log[1]);
        end
        n_cmp++;
        if (res_data_log[0] !== 8'h37 || res_data_log[1] !== 8'hA1) begin
            n_bad++; $display("FAIL two_res_data: got %h,%h want 37,a1", res_data_log[0], res_data_log[1]);
        end
        n_cmp++;
        if (fail_mask !== 4'b0000) begin n_bad++; $display("FAIL two_fail_mask: got %b want 0000", fail_mask); end
        @(posedge clk); #1;
        $display("two_ranks: cycles=%0d mrs=%0d res=%0d", cyc, mrs_cnt, res_cnt);
    endtask

    task automatic test_lane_fail();
        bit ok; int cyc;
        clear_logs();
        eng_result[2] = 8'h6C; eng_status[2] = 2'b01;   // lane 1 fails
        pulse_start(4'b0100);
        wait_done(5000, ok, cyc);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL lane_done: got timeout want done"); end
        n_cmp++;
        if (res_cnt !== 1 || res_rank_log[0] !== 2'd2 || res_data_log[0] !== 8'h6C) begin
            n_bad++; $display("FAIL lane_res: got cnt=%0d rank=%0d data=%h want 1/2/6c", res_cnt, res_rank_log[0], res_data_log[0]);
        end
        n_cmp++;
        if (fail_mask !== 4'b0100) begin n_bad++; $display("FAIL lane_fail_mask: got %b want 0100", fail_mask); end
        n_cmp++;
        if (mrs_cnt !== 2) begin n_bad++; $display("FAIL lane_mrs_cnt: got %0d want 2", mrs_cnt); end
        @(posedge clk); #1;
        $display("lane_fail: res=%0d fail=%b", res_cnt, fail_mask);
    endtask

    task automatic test_timeout();
        bit ok; bit seen; int cyc; int cnt;
        clear_logs();
        eng_never = 1'b1;
        pulse_start(4'b0001);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (trng_init == '1) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL tmo_init: got no trng_init want pulse"); end
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (fail_mask[0]) break;
        end
        n_cmp++;
        if (cnt !== 1023) begin n_bad++; $display("FAIL tmo_cycles: got %0d want 1023", cnt); end
        n_cmp++;
        if (mrs_req !== 1'b1 || mrs_data !== 16'h0044) begin
            n_bad++; $display("FAIL tmo_mrs_off: got req=%b data=%h want 1/0044", mrs_req, mrs_data);
        end
        wait_done(200, ok, cyc);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL tmo_done: got timeout want done"); end
        n_cmp++;
        if (res_cnt !== 0) begin n_bad++; $display("FAIL tmo_res_cnt: got %0d want 0", res_cnt); end
        n_cmp++;
        if (fail_mask !== 4'b0001 || mrs_cnt !== 2) begin
            n_bad++; $display("FAIL tmo_summary: got fail=%b mrs=%0d want 0001/2", fail_mask, mrs_cnt);
        end
        eng_never = 1'b0;
        @(posedge clk); #1;
        $display("timeout: cycles=%0d fail=%b mrs=%0d", cnt, fail_mask, mrs_cnt);
    endtask

    task automatic test_delayed_ack();
        bit ok; bit seen; int cyc; int stable;
        clear_logs();
        ack_delay = 7; mr1_val = 16'h1234;
        eng_result[0] = 8'h95; eng_status[0] = 2'b11;
        pulse_start(4'b0001);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mrs_req) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL dly_req: got no mrs_req want request"); end
        stable = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            start = (i == 2);    // stray start pulse while waiting for ack
            if (mrs_req === 1'b1 && mrs_data === 16'h12B4 && mrs_rank === 2'd0) stable++;
        end
        start = 1'b0;
        n_cmp++;
        if (stable !== 7) begin n_bad++; $display("FAIL dly_stable: got %0d cycles want 7", stable); end
        repeat (50) @(posedge clk);
        #1;
        pulse_start(4'b1111);    // stray start during training
        wait_done(5000, ok, cyc);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL dly_done: got timeout want done"); end
        n_cmp++;
        if (mrs_cnt !== 2 || mrs_data_log[1] !== 16'h1234) begin
            n_bad++; $display("FAIL dly_mrs: got cnt=%0d off=%h want 2/1234", mrs_cnt, mrs_data_log[1]);
        end
        n_cmp++;
        if (res_cnt !== 1) begin n_bad++; $display("FAIL dly_res_cnt: got %0d want 1", res_cnt); end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL dly_no_restart: got busy=%b want 0", busy); end
        ack_delay = 0; mr1_val = 16'h0044;
        $display("delayed_ack: stable=%0d mrs=%0d res=%0d", stable, mrs_cnt, res_cnt);
    endtask

    task automatic test_reset_midrun();
        bit seen;
        clear_logs();
        eng_result[2] = 8'h5A; eng_status[2] = 2'b11;
        pulse_start(4'b0100);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (trng_init == '1) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL rst_init: got no trng_init want pulse"); end
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({mrs_req, mrs_rank, mrs_data} !== 19'd0) begin
            n_bad++; $display("FAIL rst_mid_mrs: got %0h want 0", {mrs_req, mrs_rank, mrs_data});
        end
        n_cmp++;
        if ({rank_sel, trng_init, res_we, res_rank, res_data} !== 17'd0) begin
            n_bad++; $display("FAIL rst_mid_trn: got %0h want 0", {rank_sel, trng_init, res_we, res_rank, res_data});
        end
        n_cmp++;
        if ({busy, done, fail_mask} !== 6'd0) begin
            n_bad++; $display("FAIL rst_mid_status: got %0h want 0", {busy, done, fail_mask});
        end
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, mrs_req} !== 2'b00) begin
            n_bad++; $display("FAIL rst_mid_idle: got busy,req=%b want 00", {busy, mrs_req});
        end
        $display("reset_midrun: outputs cleared, busy=%b", busy);
    endtask

    task automatic test_empty_run();
        clear_logs();
        pulse_start(4'b0000);
        n_cmp++;
        if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL empty_c1: got busy,done=%b want 10", {busy, done}); end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done} !== 2'b11) begin n_bad++; $display("FAIL empty_c2: got busy,done=%b want 11", {busy, done}); end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL empty_c3: got busy,done=%b want 00", {busy, done}); end
        n_cmp++;
        if (mrs_cnt !== 0) begin n_bad++; $display("FAIL empty_mrs: got %0d want 0", mrs_cnt); end
        $display("empty_run: mrs=%0d", mrs_cnt);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        rank_en = 4'd0;
        mr1_val = 16'h0044;
        twlmrd  = 6'd4;
        for (int r = 0; r < 4; r++) begin
            eng_result[r] = 8'h00;
            eng_status[r] = 2'b11;
        end
        test_reset();
        test_single_rank();
        test_two_ranks();
        test_lane_fail();
        test_timeout();
        test_delayed_ack();
        test_reset_midrun();
        test_empty_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ehl_ddr_wrlvl_ctrl.md
# ehl_ddr_wrlvl_ctrl

DDR3 write-leveling sequencer sitting between the PHY init/DFI control logic and the per-byte-lane write-leveling training engines. It trains each enabled rank in turn:
- issues the MR1 write that enables write-leveling mode;
- waits tWLMRD;
- starts all lane engines together and collects their coefficients and pass/fail status;
- issues the MR1 write that exits write-leveling mode.

Results are written into the PHY delay-register file, one word per rank.

## Interface
Parameters:
- LANES, 2, number of byte lanes / training engines (1..8)
- TMO, 1023, training timeout in clk cycles per rank (engines need ~520)

Ports:
- clk  input  1  single clock, all logic on posedge
- reset_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse, starts a full leveling run
- rank_en  input  4  ranks to train, bit r = rank r
- mr1_val  input  16  operational MR1 value; bit 7 (Level) is forced by the block
- twlmrd  input  6  wait after MRS before first engine start, cycles (0 treated as 1)
- mrs_req  output  1  MRS request to command path
- mrs_rank  output  2  target rank of mrs_req
- mrs_data  output  16  MR1 payload
- mrs_ack  input  1  command path accepted request this cycle
- rank_sel  output  4  one-hot rank currently under leveling (to engines/ODT), 0 when idle
- trng_init  output  LANES  one-cycle start pulse to each engine
- trng_done  input  LANES  engine done levels
- trng_status  input  LANES  engine pass (1) / fail (0)
- trng_result  input  4*LANES  engine coefficients, lane i at [4i+3:4i]
- res_we  output  1  one-cycle write strobe to delay-register file
- res_rank  output  2  rank index of res_data
- res_data  output  4*LANES  captured coefficients
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at end of run
- fail_mask  output  4  bit r set if rank r failed (any lane fail or timeout); cleared on start

## Operation
States: IDLE, SEL, MRS_ON, WAIT_ON, TRN_START, TRN_WAIT, STORE, MRS_OFF, WAIT_OFF, FIN.

- IDLE: on start, clear fail_mask, go to SEL. start in any other state is ignored.
- SEL: pick the lowest-index enabled rank not yet trained (rank pointer starts at 0).
  - Rank found: load rank_sel and go to MRS_ON.
  - None left: go to FIN.
- MRS_ON: mrs_req=1, mrs_rank=rank, mrs_data=mr1_val with bit7=1.
  - Held stable until mrs_ack; mrs_ack high at the same edge → WAIT_ON.
- WAIT_ON: counter loaded with max(twlmrd,1); decrements each cycle; reaching 0 → TRN_START.
- TRN_START: trng_init all bits 1 for exactly one cycle; timeout counter loaded with TMO; → TRN_WAIT.
- TRN_WAIT:
  - Stale done values are never sampled: engines clear done on the edge that samples init.
  - All trng_done bits 1 → STORE.
  - Timeout counter reaches 0 first → set fail_mask[rank], go to MRS_OFF without writing results.
- STORE: res_we=1, res_rank=rank, res_data=trng_result. If any trng_status bit is 0, set fail_mask[rank]. → MRS_OFF.
- MRS_OFF: as MRS_ON with mrs_data=mr1_val, bit7=0; on ack → WAIT_OFF.
- WAIT_OFF: same counter as WAIT_ON; then mark the rank trained and go to SEL.
- FIN: done=1 for one cycle; → IDLE.
- rank_en is sampled only at start; later changes do not affect the run. rank_en=0 → SEL→FIN directly.

## Timing
- Reset (reset_n low at a posedge): state IDLE.
  - All outputs 0 from that edge: mrs_req, mrs_rank, mrs_data, rank_sel, trng_init, res_we, res_rank, res_data, busy, done, fail_mask.
- Reset mid-run aborts immediately, including a pending mrs_req. Re-issuing MR1 exit is the responsibility of init logic.
- All outputs are registered; no combinational path from inputs to outputs.
- busy is 1 from the cycle after start through FIN inclusive.
- Latency per rank with immediate ack and T = twlmrd: 1 (SEL) + 1 (MRS_ON) + T + 1 (TRN_START) + engine time + 1 (STORE) + 1 + T.
- Empty run: start at edge n → busy at n+1, done at n+2, busy low at n+3.
- Counters are 6-bit (wait) and ceil(log2(TMO+1))-bit (timeout); neither wraps because they are loaded before use.

## Test plan
- rank_en=4'b0001, twlmrd=4, engine model done after 520 cycles with status all 1, results 4'h5/4'h9:
  - mrs_data bit7=1, then bit7=0;
  - one res_we with res_rank=0, res_data={4'h9,4'h5};
  - fail_mask=0; done pulse.
- rank_en=4'b1010: ranks trained in order 1 then 3; rank_sel 4'b0010 then 4'b1000; two res_we; exactly four MRS requests.
- Lane 1 reports status 0 on rank 2: res_we still fires; fail_mask=4'b0100.
- Engine never asserts done, TMO=1023: no res_we; fail_mask[rank] set exactly 1023 cycles after TRN_START; MR1 exit still issued.
- mrs_ack delayed 7 cycles: mrs_req/mrs_data stable for all 7 cycles; start pulses during the run are ignored.
- reset_n low during TRN_WAIT: next edge all outputs 0, state IDLE. rank_en=0 with start: done exactly 2 cycles after start, no mrs_req.
